// File: rtl/spi_amp_adc_seq_pkg.sv
// Shared definitions for the amp/ADC SPI sequencer: FSM states, frame
// geometry and the two's-complement to offset-binary sample formatter.
package spi_amp_adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AMP,
    ST_AMP_GAP,
    ST_CONV,
    ST_ADC,
    ST_DONE
  } seq_state_t;

  // Amp gain word is always one byte, {chB, chA}
  localparam int AMP_FRAME_BITS = 8;

  // Channel 0 data starts after the two leading zero bits of the ADC frame
  localparam int CH0_START = 2;

  // ADC frame: two channels, each with ADC_BITS data plus 3 padding clocks
  function automatic int adc_frame_bits(input int adc_bits);
    return 2 * (adc_bits + 3);
  endfunction

  // Channel 1 data starts after channel 0 and its trailing padding
  function automatic int ch1_start(input int adc_bits);
    return adc_bits + 5;
  endfunction

  // Keep the top out_bits of a two's-complement word and flip the sign bit
  function automatic logic [31:0] to_offset_bin(input logic [31:0] word,
                                                input int adc_bits,
                                                input int out_bits);
    logic [31:0] v;
    v = word >> (adc_bits - out_bits);
    v = v & ((32'd1 << out_bits) - 32'd1);
    v = v ^ (32'd1 << (out_bits - 1));
    return v;
  endfunction

endpackage

// File: rtl/spi_amp_adc_seq_clk_gen.sv
// spi_clk_gen: divides clk by 2*CLK_DIV into an SPI clock that runs only
// while run is high and rests low otherwise. rise_stb/fall_stb are high in
// the clk cycle whose closing edge makes spi_clk rise/fall.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic spi_clk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          edge_now;

  assign edge_now = run && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = edge_now && !spi_clk;
  assign fall_stb = edge_now && spi_clk;

  // Half-period counter; toggles spi_clk every CLK_DIV cycles while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (edge_now) begin
      cnt     <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_amp_adc_seq.sv
// Autonomous SPI sequencer for pre-amp + dual ADC: per sample slot, programs
// amp gain when it changed, pulses CONV, shifts in both channels, and emits
// offset-binary samples with a one-cycle sample_valid. Macro AVG4_EN: 4-frame average.
module spi_amp_adc_seq
  import spi_amp_adc_seq_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int ADC_BITS      = 14,
  parameter int OUT_BITS      = 8,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          gain,
  input  logic                spi_miso,
  output logic                spi_mosi,
  output logic                spi_clk,
  output logic                amp_cs,
  output logic                amp_shdn,
  output logic                adc_conv,
  output logic [OUT_BITS-1:0] sample0,
  output logic [OUT_BITS-1:0] sample1,
  output logic                sample_valid,
  output logic                busy
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] PH_LAST   = CW'(CLK_DIV - 1);
  localparam logic [7:0]    AMP_LAST  = 8'(AMP_FRAME_BITS - 1);
  localparam logic [7:0]    FRAME_END = 8'(adc_frame_bits(ADC_BITS));
  localparam logic [7:0]    C0_LO     = 8'(CH0_START);
  localparam logic [7:0]    C0_HI     = 8'(CH0_START + ADC_BITS);
  localparam logic [7:0]    C1_LO     = 8'(ch1_start(ADC_BITS));
  localparam logic [7:0]    C1_HI     = 8'(ch1_start(ADC_BITS) + ADC_BITS);

  seq_state_t            state;
  logic [TW-1:0]         timer;
  logic                  slot_start;
  logic [CW-1:0]         phase;
  logic [7:0]            bit_cnt;
  logic [6:0]            amp_sr;
  logic [7:0]            last_gain;
  logic                  gain_loaded;
  logic [ADC_BITS-1:0]   ch0_sr;
  logic [ADC_BITS-1:0]   ch1_sr;
  logic [OUT_BITS-1:0]   fmt0;
  logic [OUT_BITS-1:0]   fmt1;
  logic                  run;
  logic                  rise_stb;
  logic                  fall_stb;

`ifdef AVG4_EN
  localparam int AW = OUT_BITS + 2;
  logic [AW-1:0] acc0;
  logic [AW-1:0] acc1;
  logic [AW-1:0] sum0;
  logic [AW-1:0] sum1;
  logic [1:0]    avg_cnt;
  logic          en_q;

  assign sum0 = acc0 + AW'(fmt0);
  assign sum1 = acc1 + AW'(fmt1);
`endif

  assign amp_shdn   = 1'b0;
  assign busy       = (state != ST_IDLE);
  assign run        = (state == ST_AMP) || (state == ST_ADC);
  assign slot_start = enable && (timer == '0);

  assign fmt0 = OUT_BITS'(to_offset_bin(32'(ch0_sr), ADC_BITS, OUT_BITS));
  assign fmt1 = (CHANNELS == 2) ? OUT_BITS'(to_offset_bin(32'(ch1_sr), ADC_BITS, OUT_BITS))
                                : '0;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (reset),
    .run     (run),
    .spi_clk (spi_clk),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  // Sample slot timer: free-runs while enabled, held at 0 otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == TW'(SAMPLE_PERIOD - 1)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Frame sequencer with registered SPI strobes and sample outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      spi_mosi     <= 1'b0;
      amp_cs       <= 1'b1;
      adc_conv     <= 1'b0;
      sample0      <= '0;
      sample1      <= '0;
      sample_valid <= 1'b0;
      phase        <= '0;
      bit_cnt      <= '0;
      amp_sr       <= '0;
      last_gain    <= '0;
      gain_loaded  <= 1'b0;
      ch0_sr       <= '0;
      ch1_sr       <= '0;
`ifdef AVG4_EN
      acc0         <= '0;
      acc1         <= '0;
      avg_cnt      <= '0;
      en_q         <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (slot_start) begin
            if (!gain_loaded || (gain != last_gain)) begin
              state     <= ST_AMP;
              amp_cs    <= 1'b0;
              spi_mosi  <= gain[7];
              amp_sr    <= gain[6:0];
              last_gain <= gain;
              bit_cnt   <= '0;
            end else begin
              state    <= ST_CONV;
              adc_conv <= 1'b1;
              phase    <= '0;
            end
          end
        end
        ST_AMP: begin
          // MOSI advances on each falling spi_clk edge
          if (fall_stb) begin
            if (bit_cnt == AMP_LAST) begin
              state       <= ST_AMP_GAP;
              amp_cs      <= 1'b1;
              spi_mosi    <= 1'b0;
              gain_loaded <= 1'b1;
              phase       <= '0;
            end else begin
              spi_mosi <= amp_sr[6];
              amp_sr   <= {amp_sr[5:0], 1'b0};
              bit_cnt  <= bit_cnt + 8'd1;
            end
          end
        end
        ST_AMP_GAP: begin
          if (phase == PH_LAST) begin
            state    <= ST_CONV;
            adc_conv <= 1'b1;
            phase    <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_CONV: begin
          if (phase == PH_LAST) begin
            state    <= ST_ADC;
            adc_conv <= 1'b0;
            bit_cnt  <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_ADC: begin
          // bit_cnt holds the index of the rising edge being sampled
          if (rise_stb) begin
            if ((bit_cnt >= C0_LO) && (bit_cnt < C0_HI))
              ch0_sr <= {ch0_sr[ADC_BITS-2:0], spi_miso};
            if ((bit_cnt >= C1_LO) && (bit_cnt < C1_HI))
              ch1_sr <= {ch1_sr[ADC_BITS-2:0], spi_miso};
            bit_cnt <= bit_cnt + 8'd1;
          end
          if (fall_stb && (bit_cnt == FRAME_END)) begin
            state <= ST_DONE;
`ifdef AVG4_EN
            if (avg_cnt == 2'd3) begin
              sample0      <= OUT_BITS'(sum0 >> 2);
              sample1      <= OUT_BITS'(sum1 >> 2);
              sample_valid <= 1'b1;
              acc0         <= '0;
              acc1         <= '0;
              avg_cnt      <= '0;
            end else begin
              acc0    <= sum0;
              acc1    <= sum1;
              avg_cnt <= avg_cnt + 2'd1;
            end
`else
            sample0      <= fmt0;
            sample1      <= fmt1;
            sample_valid <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
`ifdef AVG4_EN
      // Dropping enable restarts the averaging window
      en_q <= enable;
      if (en_q && !enable) begin
        acc0    <= '0;
        acc1    <= '0;
        avg_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_amp_adc_seq.sv
// Directed bench for spi_amp_adc_seq: amp frame content, ADC frame timing,
// sample formatting, gain reprogramming, enable and reset handling.
module tb_spi_amp_adc_seq;

  localparam int PERIOD = 500;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] gain;
  logic       spi_miso;
  logic       spi_mosi;
  logic       spi_clk;
  logic       amp_cs;
  logic       amp_shdn;
  logic       adc_conv;
  logic [7:0] sample0;
  logic [7:0] sample1;
  logic       sample_valid;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Per-slot observations
  int         amp_rises, amp_cs_low, conv_cycles, adc_rises, valid_cycles, first_busy;
  logic [7:0] amp_bits, s0, s1, s0_hold, s1_hold;

  always #5 clk = ~clk;

  spi_amp_adc_seq #(
    .CHANNELS(2), .ADC_BITS(14), .OUT_BITS(8), .CLK_DIV(4), .SAMPLE_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .gain(gain), .spi_miso(spi_miso),
    .spi_mosi(spi_mosi), .spi_clk(spi_clk), .amp_cs(amp_cs), .amp_shdn(amp_shdn),
    .adc_conv(adc_conv), .sample0(sample0), .sample1(sample1),
    .sample_valid(sample_valid), .busy(busy)
  );

  // ADC serial model: value presented before rising edge k of the ADC frame
  function automatic logic miso_bit(input int k, input logic [13:0] c0, input logic [13:0] c1);
    logic [13:0] w;
    if (k >= 2 && k <= 15) begin
      w = c0 >> (15 - k);
      return w[0];
    end
    if (k >= 19 && k <= 32) begin
      w = c1 >> (32 - k);
      return w[0];
    end
    return 1'b1;
  endfunction

  // Observe one frame until busy falls. act_kind: 0 none, 1 gain change,
  // 2 assert reset (returns immediately), 3 drop enable; fired at ADC rise act_at.
  task automatic run_slot(input logic [13:0] c0, input logic [13:0] c1,
                          input int act_at, input int act_kind, input logic [7:0] new_gain);
    logic prev_sck, prev_busy, in_adc, acted;
    int   after;
    amp_rises = 0; amp_cs_low = 0; conv_cycles = 0; adc_rises = 0; valid_cycles = 0;
    first_busy = -1; amp_bits = '0; s0 = '0; s1 = '0;
    prev_sck = spi_clk; prev_busy = busy; in_adc = 1'b0; acted = 1'b0; after = -1;
    for (int cyc = 0; cyc < 2 * PERIOD; cyc++) begin
      @(negedge clk);
      if (busy && first_busy < 0) first_busy = cyc;
      if (!amp_cs) amp_cs_low++;
      if (adc_conv) begin
        conv_cycles++;
        in_adc = 1'b1;
      end
      if (spi_clk && !prev_sck) begin
        if (!amp_cs) begin
          amp_rises++;
          amp_bits = {amp_bits[6:0], spi_mosi};
        end else if (in_adc) begin
          adc_rises++;
        end
      end
      prev_sck = spi_clk;
      if (sample_valid) begin
        if (valid_cycles == 0) begin
          s0 = sample0;
          s1 = sample1;
        end
        valid_cycles++;
      end
      if (in_adc && !acted && act_kind != 0 && adc_rises == act_at) begin
        acted = 1'b1;
        if (act_kind == 1) gain = new_gain;
        if (act_kind == 3) enable = 1'b0;
        if (act_kind == 2) begin
          reset = 1'b1;
          return;
        end
      end
      spi_miso = miso_bit(adc_rises, c0, c1);
      if (prev_busy && !busy) after = 0;
      prev_busy = busy;
      if (after >= 0) begin
        after++;
        if (after == 4) begin
          s0_hold = sample0;
          s1_hold = sample1;
          return;
        end
      end
    end
    tests++; fails++;
    $display("FAIL slot_timeout: frame not finished after %0d cycles, required within %0d", 2 * PERIOD, 2 * PERIOD);
  endtask

  task automatic test_reset();
    int busy_cnt;
    reset = 1'b1; enable = 1'b0; gain = 8'h11; spi_miso = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({spi_mosi, spi_clk, amp_cs, amp_shdn, adc_conv, sample_valid, busy} !== 7'b0010000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 0010000",
               {spi_mosi, spi_clk, amp_cs, amp_shdn, adc_conv, sample_valid, busy});
    end
    tests++;
    if ({sample0, sample1} !== 16'h0000) begin
      fails++; $display("FAIL reset_samples: got %h, required 0000", {sample0, sample1});
    end
    reset = 1'b0;
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    tests++;
    if (busy_cnt !== 0) begin
      fails++; $display("FAIL idle_when_disabled: busy cycles %0d, required 0", busy_cnt);
    end
  endtask

  task automatic test_first_slot();
    enable = 1'b1;
    run_slot(14'h1FFF, 14'h2000, 0, 0, 8'h00);
    tests++; if (amp_rises !== 8) begin fails++; $display("FAIL amp_clocks: got %0d, required 8", amp_rises); end
    tests++; if (amp_bits !== 8'h11) begin fails++; $display("FAIL amp_bits: got %h, required 11", amp_bits); end
    tests++; if (amp_cs_low !== 64) begin fails++; $display("FAIL amp_cs_low: got %0d, required 64", amp_cs_low); end
    tests++; if (conv_cycles !== 4) begin fails++; $display("FAIL conv_width: got %0d, required 4", conv_cycles); end
    tests++; if (adc_rises !== 34) begin fails++; $display("FAIL adc_clocks: got %0d, required 34", adc_rises); end
    tests++; if (valid_cycles !== 1) begin fails++; $display("FAIL valid_width: got %0d, required 1", valid_cycles); end
    tests++; if (s0 !== 8'hFF) begin fails++; $display("FAIL first_s0: got %h, required ff", s0); end
    tests++; if (s1 !== 8'h00) begin fails++; $display("FAIL first_s1: got %h, required 00", s1); end
    tests++; if (s0_hold !== 8'hFF) begin fails++; $display("FAIL s0_hold: got %h, required ff", s0_hold); end
  endtask

  task automatic test_no_reprogram();
    run_slot(14'h0000, 14'h3FFF, 0, 0, 8'h00);
    tests++; if (amp_cs_low !== 0) begin fails++; $display("FAIL no_amp_frame: amp_cs low %0d, required 0", amp_cs_low); end
    tests++; if (conv_cycles !== 4) begin fails++; $display("FAIL conv_width2: got %0d, required 4", conv_cycles); end
    tests++; if (adc_rises !== 34) begin fails++; $display("FAIL adc_clocks2: got %0d, required 34", adc_rises); end
    tests++; if (s0 !== 8'h80) begin fails++; $display("FAIL zero_s0: got %h, required 80", s0); end
    tests++; if (s1 !== 8'h7F) begin fails++; $display("FAIL neg1_s1: got %h, required 7f", s1); end
  endtask

  task automatic test_gain_change_mid_adc();
    run_slot(14'h1234, 14'h2ABC, 10, 1, 8'h22);
    tests++; if (amp_rises !== 0) begin fails++; $display("FAIL midgain_no_amp: got %0d, required 0", amp_rises); end
    tests++; if (s0 !== 8'hC8) begin fails++; $display("FAIL midgain_s0: got %h, required c8", s0); end
    tests++; if (s1 !== 8'h2A) begin fails++; $display("FAIL midgain_s1: got %h, required 2a", s1); end
    run_slot(14'h1FFF, 14'h2000, 0, 0, 8'h00);
    tests++; if (amp_rises !== 8) begin fails++; $display("FAIL reprog_clocks: got %0d, required 8", amp_rises); end
    tests++; if (amp_bits !== 8'h22) begin fails++; $display("FAIL reprog_bits: got %h, required 22", amp_bits); end
  endtask

  task automatic test_enable_drop();
    int busy_cnt;
    run_slot(14'h0000, 14'h0000, 5, 3, 8'h00);
    tests++; if (valid_cycles !== 1) begin fails++; $display("FAIL endrop_valid: got %0d, required 1", valid_cycles); end
    tests++; if ({s0, s1} !== 16'h8080) begin fails++; $display("FAIL endrop_samples: got %h, required 8080", {s0, s1}); end
    busy_cnt = 0;
    repeat (PERIOD + 50) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL endrop_idle: busy cycles %0d, required 0", busy_cnt); end
    enable = 1'b1;
    run_slot(14'h1FFF, 14'h0000, 0, 0, 8'h00);
    tests++; if (first_busy !== 0) begin fails++; $display("FAIL enable_start: busy at cycle %0d, required 0", first_busy); end
    tests++; if (amp_rises !== 0) begin fails++; $display("FAIL enable_no_amp: got %0d, required 0", amp_rises); end
    tests++; if ({s0, s1} !== 16'hFF80) begin fails++; $display("FAIL enable_samples: got %h, required ff80", {s0, s1}); end
  endtask

  task automatic test_reset_mid_frame();
    run_slot(14'h1FFF, 14'h2000, 21, 2, 8'h00);
    #1;
    tests++;
    if ({spi_mosi, spi_clk, amp_cs, adc_conv, sample_valid, busy} !== 6'b001000) begin
      fails++;
      $display("FAIL midreset_ctrl: got %b, required 001000",
               {spi_mosi, spi_clk, amp_cs, adc_conv, sample_valid, busy});
    end
    tests++;
    if ({sample0, sample1} !== 16'h0000) begin
      fails++; $display("FAIL midreset_samples: got %h, required 0000", {sample0, sample1});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_slot(14'h3FFF, 14'h1FFF, 0, 0, 8'h00);
    tests++; if (amp_rises !== 8) begin fails++; $display("FAIL after_reset_amp: got %0d, required 8", amp_rises); end
    tests++; if (amp_bits !== 8'h22) begin fails++; $display("FAIL after_reset_bits: got %h, required 22", amp_bits); end
    tests++; if (valid_cycles !== 1) begin fails++; $display("FAIL after_reset_valid: got %0d, required 1", valid_cycles); end
    tests++; if ({s0, s1} !== 16'h7FFF) begin fails++; $display("FAIL after_reset_samples: got %h, required 7fff", {s0, s1}); end
  endtask

`ifdef AVG4_EN
  task automatic test_avg4();
    logic [13:0] codes [4];
    codes[0] = 14'h2400; codes[1] = 14'h2800; codes[2] = 14'h2C00; codes[3] = 14'h3040;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_slot(codes[i], 14'h2000, 0, 0, 8'h00);
      tests++;
      if (valid_cycles !== ((i == 3) ? 1 : 0)) begin
        fails++; $display("FAIL avg_valid_frame%0d: got %0d, required %0d", i, valid_cycles, (i == 3) ? 1 : 0);
      end
    end
    tests++; if (s0 !== 8'h28) begin fails++; $display("FAIL avg_s0: got %h, required 28", s0); end
    tests++; if (s1 !== 8'h00) begin fails++; $display("FAIL avg_s1: got %h, required 00", s1); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AVG4_EN
    test_avg4();
`else
    test_first_slot();
    test_no_reprogram();
    test_gain_change_mid_adc();
    test_enable_drop();
    test_reset_mid_frame();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_amp_adc_seq.md
Name: spi_amp_adc_seq

Overview:
- Autonomous SPI sequencer for the programmable pre-amp plus dual-channel ADC front end.
- Replaces the separate amp/adc controllers and the top-level SPI_CLK/SPI_MOSI select mux with one parametrised block.
- Owns the shared SPI bus and paces conversions from a programmable sample timer.
- Reprograms amp gain only when the requested gain changes.
- Delivers offset-binary samples with a one-cycle valid strobe to the fuzzy controller and display path.

Parameters:
- CHANNELS, 2, number of ADC channels captured (1 or 2); the frame length is unchanged.
- ADC_BITS, 14, ADC word width (two's complement).
- OUT_BITS, 8, output sample width (1..ADC_BITS).
- CLK_DIV, 4, clk cycles per spi_clk half-period (>=2).
- SAMPLE_PERIOD, 5000, clk cycles between sample-slot starts; must be >= amp frame + ADC frame length.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run sampling; when low, the sequencer idles after the current frame.
- gain  in  8  requested amp gain {chB[3:0], chA[3:0]}.
- spi_miso  in  1  ADC serial data.
- spi_mosi  out  1  amp serial data.
- spi_clk  out  1  shared SPI clock.
- amp_cs  out  1  amp chip select, active low.
- amp_shdn  out  1  amp shutdown, held 0.
- adc_conv  out  1  ADC conversion start.
- sample0  out  OUT_BITS  channel 0 result.
- sample1  out  OUT_BITS  channel 1 result.
- sample_valid  out  1  one-cycle pulse when new samples are presented.
- busy  out  1  high while any frame is in progress.

Behaviour:
- Reset values (asynchronous): spi_mosi=0, spi_clk=0, amp_cs=1, amp_shdn=0, adc_conv=0, sample0/1=0, sample_valid=0, busy=0. Sample timer=0, gain_loaded flag cleared.
- Reset asserted mid-frame aborts the frame immediately; no partial sample is ever presented.
- SPI clock: spi_clk toggles every CLK_DIV clk cycles, and only inside frames; it rests at 0.
  - MOSI changes on the spi_clk falling edge.
  - MISO is sampled on the clk cycle spi_clk rises.
- Sample timer: counts 0..SAMPLE_PERIOD-1 while enable=1 and wraps. A slot starts at count 0.
- If enable drops, the timer clears. When enable rises, a slot starts on the next cycle.
- FSM states:
  - IDLE: at slot start, go to AMP if gain != last_gain or gain_loaded=0; otherwise go to CONV.
  - AMP: amp_cs=0; shift 8 bits of gain, MSB first, over 8 spi_clk cycles. Latch last_gain=gain at frame start; a gain change during the frame applies next slot.
  - AMP_GAP: amp_cs=1 for one half-period. Set gain_loaded. Go to CONV.
  - CONV: adc_conv=1 for exactly one half-period (CLK_DIV cycles), then 0.
  - ADC: 2*(ADC_BITS+3) spi_clk cycles (34 at default).
    - Bits 2..ADC_BITS+1 form channel 0.
    - Bits ADC_BITS+5..2*ADC_BITS+4 form channel 1.
    - Both fields are MSB first; bit index counts from 0 at the first rising edge.
  - DONE: present results, then go to IDLE.
- busy=1 in every state except IDLE.
- Output formatting: sample = top OUT_BITS of the ADC word with the MSB inverted (offset binary; 0x80 = zero input for 8 bits). When CHANNELS=1, sample1 stays 0.
- sample0/1 update and sample_valid pulses high for 1 cycle in the same cycle, on entry to DONE.
- Outputs hold their value between updates.
- Slot start with busy=1 (period too short): that slot is skipped, with no queueing.
- enable low mid-frame: the frame completes, sample_valid still fires, then the FSM idles.

Optional Feature:
- Macro AVG4_EN.
- Defined:
  - Each channel accumulates 4 consecutive formatted samples in an (OUT_BITS+2)-bit sum.
  - Outputs = sum>>2 (truncating).
  - sample_valid fires every 4th ADC frame only.
  - The accumulators and frame count clear on reset and when enable falls.
- Undefined: every frame updates the outputs directly, as described above.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - the frame-length constants AMP_FRAME_BITS=8 and ADC_FRAME_BITS=2*(ADC_BITS+3);
  - the channel field start offsets;
  - the offset-binary conversion function.
- One sub-module: spi_clk_gen (CLK_DIV divider). Inputs: run. Outputs: spi_clk, rise_stb, fall_stb. Reused by the DAC path later.

Test Plan:
- After reset, enable=1, gain=0x11 → first slot: amp frame shifts 00010001 MSB first with amp_cs low for 8 spi_clk cycles, then adc_conv high for 4 clks, then 34 spi_clk cycles.
- Next slot with gain unchanged → no amp frame; amp_cs stays 1.
- MISO model returns ch0=0x1FFF and ch1=0x2000 (14-bit) → sample0=0xFF, sample1=0x00, sample_valid high for exactly 1 cycle.
- Change gain to 0x22 mid-ADC frame → current results unaffected; next slot programs 0x22.
- Assert reset during bit 20 of the ADC frame → all outputs at reset values in the same cycle; no sample_valid.
- With AVG4_EN, four frames with ch0 codes giving samples 0x10, 0x20, 0x30, 0x41 → single sample_valid after frame 4 with sample0=0x28.
